sobel_feeder: RTL and testbench

//  Transmit side of the sobel_control pixel interface. Accepts a raster grayscale frame, buffers three rows,
//  and replays each 3-row band as the serial pixel schedule sobel_control consumes: first window 10 slots, each next window 4 slots.

---
 rtl/sobel_feeder_pkg.sv | 44 ++++
 rtl/sobel_line_buffer.sv | 26 ++
 rtl/sobel_feeder.sv | 203 ++++++++++++++++++++
 tb/tb_sobel_feeder.sv | 285 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/sobel_feeder_pkg.sv
// Shared types, defaults and window-geometry helpers for the sobel pixel feeder.
// The slot helpers map a 3x3 window slot (1..9) onto its column-major row/column.
package sobel_feeder_pkg;

   localparam int PIXEL_WIDTH_DEF = 8;
   localparam int IMG_WIDTH_DEF   = 16;
   localparam int IMG_HEIGHT_DEF  = 16;
   localparam int GAP_CYCLES_DEF  = 2;
   localparam int FIRST_SLOTS     = 10;
   localparam int NEXT_SLOTS      = 4;

   typedef enum logic [2:0] {
      IDLE,
      FILL,
      EMIT_FIRST,
      EMIT_NEXT,
      GAP,
      DONE
   } feeder_state_t;

   // Modulo-3 add for row indices into the three-row ring buffer.
   function automatic logic [1:0] ring_add(input logic [1:0] a, input logic [1:0] b);
      logic [2:0] s;
      s = {1'b0, a} + {1'b0, b};
      return (s >= 3'd3) ? 2'(s - 3'd3) : s[1:0];
   endfunction

   function automatic logic [1:0] first_row_off(input logic [3:0] slot);
      case (slot)
         4'd2, 4'd5, 4'd8: return 2'd1;
         4'd3, 4'd6, 4'd9: return 2'd2;
         default:          return 2'd0;
      endcase
   endfunction

   function automatic logic [1:0] first_col(input logic [3:0] slot);
      case (slot)
         4'd4, 4'd5, 4'd6: return 2'd1;
         4'd7, 4'd8, 4'd9: return 2'd2;
         default:          return 2'd0;
      endcase
   endfunction

endpackage

// File: rtl/sobel_line_buffer.sv
// Three-row pixel store: one synchronous write port, one combinational read port.
// Contents are deliberately not reset; every location is written before it is read.
module sobel_line_buffer #(
   parameter int PIXEL_WIDTH = 8,
   parameter int IMG_WIDTH   = 16,
   localparam int CW         = $clog2(IMG_WIDTH)
) (
   input  logic                   clk_i,
   input  logic                   we,
   input  logic [1:0]             wr_row,
   input  logic [CW-1:0]          wr_col,
   input  logic [PIXEL_WIDTH-1:0] wr_data,
   input  logic [1:0]             rd_row,
   input  logic [CW-1:0]          rd_col,
   output logic [PIXEL_WIDTH-1:0] rd_data
);

   logic [PIXEL_WIDTH-1:0] mem [3][IMG_WIDTH];

   always_ff @(posedge clk_i) begin
      if (we) mem[wr_row][wr_col] <= wr_data;
   end

   assign rd_data = mem[rd_row][rd_col];

endmodule

// File: rtl/sobel_feeder.sv
// Buffers a raster frame three rows at a time and replays each band as the
// serial window schedule of sobel_control (10 slots first window, 4 per next).
module sobel_feeder
   import sobel_feeder_pkg::*;
#(
   parameter int PIXEL_WIDTH = PIXEL_WIDTH_DEF,
   parameter int IMG_WIDTH   = IMG_WIDTH_DEF,
   parameter int IMG_HEIGHT  = IMG_HEIGHT_DEF,
   parameter int GAP_CYCLES  = GAP_CYCLES_DEF
) (
   input  logic                   clk_i,
   input  logic                   nreset_i,
   input  logic                   frame_start_i,
   input  logic [PIXEL_WIDTH-1:0] px_i,
   input  logic                   px_valid_i,
   output logic                   px_ready_o,
   output logic                   start_o,
   output logic [PIXEL_WIDTH-1:0] px_gray_o,
   output logic                   px_strobe_o,
   output logic                   frame_done_o,
   output logic                   busy_o
);

   localparam int CW = $clog2(IMG_WIDTH);
   localparam int HW = $clog2(IMG_HEIGHT);
   localparam int GW = $clog2(GAP_CYCLES + 1);

   localparam logic [CW-1:0] COL_LAST   = CW'(IMG_WIDTH - 1);
   localparam logic [CW-1:0] W_END      = CW'(IMG_WIDTH - 2);
   localparam logic [HW-1:0] H_END      = HW'(IMG_HEIGHT - 2);
   localparam logic [GW-1:0] GAP_LAST   = GW'(GAP_CYCLES - 1);
   localparam logic [3:0]    FIRST_LAST = 4'(FIRST_SLOTS - 1);
   localparam logic [3:0]    NEXT_LAST  = 4'(NEXT_SLOTS - 1);

   // px_ready_o is high exactly in FILL, so a transfer implies FILL.
   // Handshake: a pixel moves on a clock edge where px_valid_i & px_ready_o;
   // the source must hold px_i stable until then.
   feeder_state_t state_q, state_d;
   logic [CW-1:0] col_q, col_d, w_q, w_d;
   logic [1:0]    wr_row_q, wr_row_d, top_q, top_d, rows_left_q, rows_left_d;
   logic [3:0]    slot_q, slot_d;
   logic [GW-1:0] gap_q, gap_d;
   logic [HW-1:0] band_q, band_d;

   logic                   fire;
   logic [1:0]             rd_row;
   logic [CW-1:0]          rd_col;
   logic [PIXEL_WIDTH-1:0] rd_data;
   logic                   emit_d, strobe_d;
   logic [PIXEL_WIDTH-1:0] gray_d;

   assign fire = px_valid_i & px_ready_o;

   sobel_line_buffer #(
      .PIXEL_WIDTH (PIXEL_WIDTH),
      .IMG_WIDTH   (IMG_WIDTH)
   ) u_line_buffer (
      .clk_i   (clk_i),
      .we      (fire),
      .wr_row  (wr_row_q),
      .wr_col  (col_q),
      .wr_data (px_i),
      .rd_row  (rd_row),
      .rd_col  (rd_col),
      .rd_data (rd_data)
   );

   // State, counters and the output registers.
   always_ff @(posedge clk_i or negedge nreset_i) begin
      if (!nreset_i) begin
         state_q      <= IDLE;
         col_q        <= '0;
         w_q          <= '0;
         wr_row_q     <= '0;
         top_q        <= '0;
         rows_left_q  <= '0;
         slot_q       <= '0;
         gap_q        <= '0;
         band_q       <= '0;
         px_ready_o   <= 1'b0;
         start_o      <= 1'b0;
         px_gray_o    <= '0;
         px_strobe_o  <= 1'b0;
         frame_done_o <= 1'b0;
         busy_o       <= 1'b0;
      end else begin
         state_q      <= state_d;
         col_q        <= col_d;
         w_q          <= w_d;
         wr_row_q     <= wr_row_d;
         top_q        <= top_d;
         rows_left_q  <= rows_left_d;
         slot_q       <= slot_d;
         gap_q        <= gap_d;
         band_q       <= band_d;
         px_ready_o   <= (state_d == FILL);
         start_o      <= emit_d;
         px_gray_o    <= gray_d;
         px_strobe_o  <= strobe_d;
         frame_done_o <= (state_d == DONE);
         busy_o       <= (state_d != IDLE);
      end
   end

   always_comb begin
      state_d     = state_q;
      col_d       = col_q;
      w_d         = w_q;
      wr_row_d    = wr_row_q;
      top_d       = top_q;
      rows_left_d = rows_left_q;
      slot_d      = slot_q;
      gap_d       = gap_q;
      band_d      = band_q;
      case (state_q)
         IDLE: begin
            if (frame_start_i) begin
               state_d     = FILL;
               rows_left_d = 2'd3;
               top_d       = 2'd0;
               col_d       = '0;
               wr_row_d    = 2'd0;
               band_d      = '0;
            end
         end
         FILL: begin
            if (fire) begin
               if (col_q == COL_LAST) begin
                  col_d       = '0;
                  wr_row_d    = ring_add(wr_row_q, 2'd1);
                  rows_left_d = rows_left_q - 2'd1;
                  if (rows_left_q == 2'd1) begin
                     state_d = EMIT_FIRST;
                     slot_d  = 4'd0;
                  end
               end else begin
                  col_d = col_q + 1'b1;
               end
            end
         end
         EMIT_FIRST: begin
            if (slot_q == FIRST_LAST) begin
               slot_d = 4'd0;
               if (IMG_WIDTH == 3) begin
                  state_d = GAP;
                  gap_d   = '0;
               end else begin
                  state_d = EMIT_NEXT;
                  w_d     = CW'(1);
               end
            end else begin
               slot_d = slot_q + 4'd1;
            end
         end
         EMIT_NEXT: begin
            if (slot_q == NEXT_LAST) begin
               slot_d = 4'd0;
               w_d    = w_q + 1'b1;
               if ((w_q + 1'b1) == W_END) begin
                  state_d = GAP;
                  gap_d   = '0;
               end
            end else begin
               slot_d = slot_q + 4'd1;
            end
         end
         GAP: begin
            if (gap_q == GAP_LAST) begin
               band_d = band_q + 1'b1;
               if ((band_q + 1'b1) == H_END) begin
                  state_d = DONE;
               end else begin
                  // The incoming row lands in wr_row, which is the oldest row (old top).
                  state_d     = FILL;
                  rows_left_d = 2'd1;
                  top_d       = ring_add(top_q, 2'd1);
               end
            end else begin
               gap_d = gap_q + 1'b1;
            end
         end
         DONE:    state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   // Outputs are computed from the next state so the registered copy lines up with it.
   always_comb begin
      emit_d   = (state_d == EMIT_FIRST) || (state_d == EMIT_NEXT);
      strobe_d = emit_d && (slot_d != 4'd0);
      rd_row   = top_d;
      rd_col   = '0;
      if (state_d == EMIT_FIRST) begin
         rd_row = ring_add(top_d, first_row_off(slot_d));
         rd_col = CW'(first_col(slot_d));
      end else if (state_d == EMIT_NEXT) begin
         rd_row = ring_add(top_d, slot_d[1:0] - 2'd1);
         rd_col = w_d + CW'(2);
      end
      gray_d = strobe_d ? rd_data : '0;
   end

endmodule

// File: tb/tb_sobel_feeder.sv
// Scoreboard bench for sobel_feeder: a 4x4 instance for band replay, backpressure
// and mid-frame reset, plus a 3x3 instance for the single-window case.
module tb_sobel_feeder;

   localparam int TW       = 4;
   localparam int TH       = 4;
   localparam int GAP      = 2;
   localparam int BAND_LEN = 10 + 4 * (TW - 3);

   logic       clk_i = 1'b0;
   logic       nreset_i;
   logic       frame_start_i, px_valid_i;
   logic [7:0] px_i;
   logic       px_ready_o, start_o, px_strobe_o, frame_done_o, busy_o;
   logic [7:0] px_gray_o;

   logic       frame_start3, valid3;
   logic [7:0] px3;
   logic       ready3, start3, strobe3, done3, busy3;
   logic [7:0] gray3;

   int n_checks = 0;
   int n_errors = 0;

   logic [7:0] exp_q[$];
   logic [7:0] exp3_q[$];

   logic mon_en;
   logic prev_start = 1'b0;
   int   run_len = 0;
   int   low_cnt = 1000;
   logic prev3 = 1'b0;
   int   run3 = 0;
   int   low3 = 1000;

   always #5 clk_i = ~clk_i;

   sobel_feeder #(
      .PIXEL_WIDTH (8), .IMG_WIDTH (TW), .IMG_HEIGHT (TH), .GAP_CYCLES (GAP)
   ) dut (
      .clk_i         (clk_i),
      .nreset_i      (nreset_i),
      .frame_start_i (frame_start_i),
      .px_i          (px_i),
      .px_valid_i    (px_valid_i),
      .px_ready_o    (px_ready_o),
      .start_o       (start_o),
      .px_gray_o     (px_gray_o),
      .px_strobe_o   (px_strobe_o),
      .frame_done_o  (frame_done_o),
      .busy_o        (busy_o)
   );

   sobel_feeder #(
      .PIXEL_WIDTH (8), .IMG_WIDTH (3), .IMG_HEIGHT (3), .GAP_CYCLES (GAP)
   ) dut3 (
      .clk_i         (clk_i),
      .nreset_i      (nreset_i),
      .frame_start_i (frame_start3),
      .px_i          (px3),
      .px_valid_i    (valid3),
      .px_ready_o    (ready3),
      .start_o       (start3),
      .px_gray_o     (gray3),
      .px_strobe_o   (strobe3),
      .frame_done_o  (done3),
      .busy_o        (busy3)
   );

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
      end
   endtask

   function automatic logic [7:0] img(input int r, input int c);
      return 8'(r * 16 + c);
   endfunction

   // Window order straight from the image: each band's first 3x3 column-major, then one column per window.
   task automatic push_frame();
      for (int b = 0; b < TH - 2; b++) begin
         for (int c = 0; c < 3; c++)
            for (int r = 0; r < 3; r++) exp_q.push_back(img(b + r, c));
         for (int c = 3; c < TW; c++)
            for (int r = 0; r < 3; r++) exp_q.push_back(img(b + r, c));
      end
   endtask

   task automatic pulse_start();
      @(posedge clk_i); #1;
      frame_start_i = 1'b1;
      @(posedge clk_i); #1;
      frame_start_i = 1'b0;
   endtask

   task automatic drive_pixels(input int first, input int last, input bit toggle);
      int  i = first;
      int  budget = 2000;
      bit  v = 1'b1;
      bit  fired;
      while (i <= last && budget > 0) begin
         px_i       = img(i / TW, i % TW);
         px_valid_i = toggle ? v : 1'b1;
         @(negedge clk_i);
         fired = px_valid_i && px_ready_o;
         @(posedge clk_i); #1;
         if (fired) i++;
         v = !v;
         budget--;
      end
      px_valid_i = 1'b0;
      check("drv_accepted", 32'(i), 32'(last + 1));
   endtask

   task automatic wait_frame_done();
      int k = 0;
      while (k < 1000 && frame_done_o !== 1'b1) begin
         @(negedge clk_i);
         k++;
      end
      check("done_seen", 32'(frame_done_o), 1);
      @(negedge clk_i);
      check("done_one_cycle", 32'(frame_done_o), 0);
      check("busy_idle", 32'(busy_o), 0);
      check("sb_drained", 32'(exp_q.size()), 0);
   endtask

   task automatic run_frame(input bit toggle);
      push_frame();
      pulse_start();
      drive_pixels(0, 3 * TW - 1, toggle);
      // Band 0 is emitting now; this second start must be ignored.
      pulse_start();
      drive_pixels(3 * TW, TW * TH - 1, toggle);
      wait_frame_done();
   endtask

   task automatic check_outputs_zero(input string tag);
      check({tag, "_ready"}, 32'(px_ready_o), 0);
      check({tag, "_start"}, 32'(start_o), 0);
      check({tag, "_gray"}, 32'(px_gray_o), 0);
      check({tag, "_strobe"}, 32'(px_strobe_o), 0);
      check({tag, "_done"}, 32'(frame_done_o), 0);
      check({tag, "_busy"}, 32'(busy_o), 0);
   endtask

   // Main-instance monitor: pops one expected pixel per strobe and checks band framing.
   always @(negedge clk_i) begin
      if (!mon_en) begin
         prev_start = 1'b0;
         low_cnt    = 1000;
         run_len    = 0;
      end else begin
         if (start_o && !prev_start) begin
            check("slot0_strobe", 32'(px_strobe_o), 0);
            run_len = 0;
         end
         if (start_o) begin
            run_len++;
            check("emit_ready", 32'(px_ready_o), 0);
            if (px_strobe_o) begin
               if (exp_q.size() == 0) check("sb_underflow", 1, 0);
               else check("pixel", 32'(px_gray_o), 32'(exp_q.pop_front()));
            end else begin
               check("idle_gray", 32'(px_gray_o), 0);
            end
         end else begin
            if (prev_start) begin
               check("band_len", 32'(run_len), BAND_LEN);
               low_cnt = 0;
            end
            if (low_cnt < GAP) check("gap_ready", 32'(px_ready_o), 0);
            if (frame_done_o) check("done_delay", 32'(low_cnt), GAP);
            check("quiet_strobe", 32'(px_strobe_o), 0);
            low_cnt++;
         end
         prev_start = start_o;
      end
   end

   always @(negedge clk_i) begin
      if (start3 && !prev3) run3 = 0;
      if (start3) begin
         run3++;
         check("w3_ready", 32'(ready3), 0);
         if (strobe3) begin
            if (exp3_q.size() == 0) check("w3_underflow", 1, 0);
            else check("w3_pixel", 32'(gray3), 32'(exp3_q.pop_front()));
         end
      end else begin
         if (prev3) begin
            check("w3_len", 32'(run3), 10);
            low3 = 0;
         end
         if (done3) check("w3_done_delay", 32'(low3), GAP);
         low3++;
      end
      prev3 = start3;
   end

   initial begin
      int strobes;
      int k;
      nreset_i      = 1'b0;
      mon_en        = 1'b0;
      frame_start_i = 1'b0;
      px_valid_i    = 1'b0;
      px_i          = '0;
      frame_start3  = 1'b0;
      valid3        = 1'b0;
      px3           = '0;
      repeat (3) @(posedge clk_i);
      @(negedge clk_i);
      check_outputs_zero("rst");
      nreset_i = 1'b1;
      mon_en   = 1'b1;

      // Two bands, valid held high.
      run_frame(1'b0);
      // Same frame with valid toggling every cycle.
      run_frame(1'b1);

      // Reset during band 0's EMIT_NEXT.
      push_frame();
      pulse_start();
      drive_pixels(0, 3 * TW - 1, 1'b0);
      strobes = 0;
      k = 0;
      while (strobes < 10 && k < 200) begin
         @(negedge clk_i);
         if (px_strobe_o) strobes++;
         k++;
      end
      check("reach_next", 32'(strobes), 10);
      mon_en = 1'b0;
      #2 nreset_i = 1'b0;
      #1 check_outputs_zero("async_rst");
      exp_q.delete();
      @(negedge clk_i);
      nreset_i = 1'b1;
      mon_en   = 1'b1;
      run_frame(1'b0);

      // 3x3 frame: one window, no EMIT_NEXT.
      for (int c = 0; c < 3; c++)
         for (int r = 0; r < 3; r++) exp3_q.push_back(8'(r * 3 + c));
      @(posedge clk_i); #1;
      frame_start3 = 1'b1;
      @(posedge clk_i); #1;
      frame_start3 = 1'b0;
      begin
         int  i = 0;
         int  budget = 200;
         bit  fired;
         while (i < 9 && budget > 0) begin
            px3    = 8'(i);
            valid3 = 1'b1;
            @(negedge clk_i);
            fired = valid3 && ready3;
            @(posedge clk_i); #1;
            if (fired) i++;
            budget--;
         end
         valid3 = 1'b0;
         check("w3_accepted", 32'(i), 9);
      end
      k = 0;
      while (k < 200 && done3 !== 1'b1) begin
         @(negedge clk_i);
         k++;
      end
      check("w3_done_seen", 32'(done3), 1);
      @(negedge clk_i);
      check("w3_done_one_cycle", 32'(done3), 0);
      check("w3_busy_idle", 32'(busy3), 0);
      check("w3_drained", 32'(exp3_q.size()), 0);

      $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
      $finish;
   end

endmodule
